// File: rtl/fifo_32b.sv
// 32-bit word FIFO on the clk_f domain, fed by the 8b->32b converter.
// Registered pop output, count-derived status flags, and overflow/underflow pulses.
module fifo_32b #(
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic              clk_f,
  input  logic              reset_L,
  input  logic [31:0]       data_in,
  input  logic              valid_in,
  input  logic              pop,
  output logic [31:0]       data_out,
  output logic              valid_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AfCount   = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AeCount   = (ADDR_W+1)'(AE_THRESH);

  logic [31:0]       mem [DEPTH];

  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       dataOut_q, dataOut_d;
  logic              validOut_q, validOut_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic              isFull, isEmpty;
  logic              pushAccept, popAccept;

  // Occupancy is tracked explicitly so full/empty never depend on pointer equality.
  assign isFull  = (count_q == FullCount);
  assign isEmpty = (count_q == '0);

  assign popAccept  = pop & ~isEmpty;
  assign pushAccept = valid_in & (~isFull | popAccept);

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    dataOut_d   = dataOut_q;
    validOut_d  = 1'b0;
    overflow_d  = valid_in & ~pushAccept;
    underflow_d = pop & isEmpty;

    if (pushAccept) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end

    if (popAccept) begin
      dataOut_d  = mem[rdPtr_q];
      validOut_d = 1'b1;
      rdPtr_d    = rdPtr_q + 1'b1;
    end

    case ({pushAccept, popAccept})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      dataOut_q   <= '0;
      validOut_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      dataOut_q   <= dataOut_d;
      validOut_q  <= validOut_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers and count make old words unreachable.
  always_ff @(posedge clk_f) begin
    if (pushAccept) begin
      mem[wrPtr_q] <= data_in;
    end
  end

  assign data_out     = dataOut_q;
  assign valid_out    = validOut_q;
  assign count        = count_q;
  assign full         = isFull;
  assign empty        = isEmpty;
  assign almost_full  = (count_q >= AfCount);
  assign almost_empty = (count_q <= AeCount);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_32b.sv
// Self-checking bench for fifo_32b: a reference queue predicts every accepted word,
// and each popped word plus all flags are compared one cycle after stimulus.
module tb_fifo_32b;

  logic        clk_f;
  logic        reset_L;
  logic [31:0] data_in;
  logic        valid_in;
  logic        pop;
  logic [31:0] data_out;
  logic        valid_out;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic        overflow;
  logic        underflow;
  logic [3:0]  count;

  int checkCount;
  int errorCount;

  logic [31:0] sbQ[$];
  logic [31:0] lastData;

  fifo_32b dut (
    .clk_f        (clk_f),
    .reset_L      (reset_L),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .count        (count)
  );

  initial clk_f = 1'b0;
  always #5 clk_f = ~clk_f;

  // Guards against a stalled run; the stimulus itself never waits on the DUT.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkFlags(input int expCount);
    checkOutput("count", 32'(count), 32'(expCount));
    checkOutput("full", 32'(full), 32'(expCount == 8));
    checkOutput("empty", 32'(empty), 32'(expCount == 0));
    checkOutput("almost_full", 32'(almost_full), 32'(expCount >= 6));
    checkOutput("almost_empty", 32'(almost_empty), 32'(expCount <= 2));
  endtask

  // Drives one cycle of stimulus, predicts the response from the reference queue,
  // then checks every output just after the capturing edge.
  task automatic applyStimulus(input logic vIn, input logic [31:0] dIn, input logic popIn);
    bit mFull, mEmpty, popAcc, pushAcc;
    logic [31:0] expData;
    @(negedge clk_f);
    valid_in = vIn;
    data_in  = dIn;
    pop      = popIn;
    mFull   = (sbQ.size() == 8);
    mEmpty  = (sbQ.size() == 0);
    popAcc  = popIn && !mEmpty;
    pushAcc = vIn && (!mFull || popAcc);
    expData = lastData;
    if (popAcc) expData = sbQ.pop_front();
    if (pushAcc) sbQ.push_back(dIn);
    lastData = expData;
    @(posedge clk_f);
    #1;
    checkOutput("valid_out", 32'(valid_out), 32'(popAcc));
    checkOutput("data_out", data_out, expData);
    checkOutput("overflow", 32'(overflow), 32'(vIn && !pushAcc));
    checkOutput("underflow", 32'(underflow), 32'(popIn && mEmpty));
    checkFlags(sbQ.size());
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_valid_out"}, 32'(valid_out), 32'd0);
    checkOutput({tag, "_data_out"}, data_out, 32'd0);
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
    checkOutput({tag, "_underflow"}, 32'(underflow), 32'd0);
    checkFlags(0);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    lastData   = 32'd0;
    valid_in   = 1'b0;
    data_in    = 32'd0;
    pop        = 1'b0;
    reset_L    = 1'b0;

    // Reset held for two clocks, released away from the edge.
    repeat (2) @(posedge clk_f);
    @(negedge clk_f);
    reset_L = 1'b1;
    #1;
    checkResetState("reset");
    applyStimulus(1'b0, 32'd0, 1'b0);

    // Short burst then drain in order.
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b1, 32'hDDDD_DDDD, 1'b0);
    applyStimulus(1'b1, 32'h0000_0003, 1'b0);
    repeat (3) applyStimulus(1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0);

    // Fill past capacity: ninth word must be dropped with an overflow pulse.
    for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 32'(i), 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b0);

    // At full, simultaneous push and pop keeps count at 8.
    applyStimulus(1'b1, 32'h0000_000A, 1'b1);
    repeat (9) applyStimulus(1'b0, 32'd0, 1'b1);

    // On empty, pop plus push: pop rejected, push stored, then popped.
    applyStimulus(1'b1, 32'h0000_0055, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0);

    // Random mixed traffic with wraparound of both pointers.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 99) < 60), $urandom, 1'($urandom_range(0, 99) < 50));
    end
    while (sbQ.size() > 0) applyStimulus(1'b0, 32'd0, 1'b1);

    // Mid-cycle asynchronous reset with words still stored.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'hA000_0000 + 32'(i), 1'b0);
    applyStimulus(1'b0, 32'd0, 1'b1);
    #2;
    reset_L = 1'b0;
    #1;
    checkResetState("async_reset");
    sbQ.delete();
    lastData = 32'd0;
    @(posedge clk_f);
    #1;
    checkResetState("held_reset");
    @(negedge clk_f);
    reset_L = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
